// File: rtl/cache_2way.sv
// 2-way set-associative, write-through cache with one word per line.
// The processor side is a strobe/ready handshake and the memory side is a strobe/ready handshake.
// Each set keeps one LRU bit that names the way to evict next.
// Optional feature: define CACHE_WRITE_ALLOCATE_EN to make a write miss install the line.
// When that macro is undefined, a write miss leaves the arrays unchanged (write-no-allocate).
module cache_2way #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              P_strobe,
  input  logic [ADDR_W-1:0] P_address,
  input  logic [DATA_W-1:0] P_wdata,
  input  logic              P_rw,
  output logic [DATA_W-1:0] P_rdata,
  output logic              P_ready,
  output logic              S_strobe,
  output logic [ADDR_W-1:0] S_address,
  output logic [DATA_W-1:0] S_wdata,
  output logic              S_rw,
  input  logic [DATA_W-1:0] S_rdata,
  input  logic              S_ready
);

  localparam int SETS  = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [2:0] {IDLE, COMPARE, MEMRD, MEMWR, RESP} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rw_q;
  logic [DATA_W-1:0] rdata_q;

  logic [SETS-1:0]   valid0, valid1, lru;
  logic [TAG_W-1:0]  tag0 [SETS];
  logic [TAG_W-1:0]  tag1 [SETS];
  logic [DATA_W-1:0] data0 [SETS];
  logic [DATA_W-1:0] data1 [SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit0, hit1, hit, hit_way, victim;
  logic [DATA_W-1:0] hit_data;

  // Array / LRU update controls produced by the FSM
  logic              arr_we;      // write the data word of arr_way
  logic              arr_install; // also write tag and set valid
  logic              arr_way;
  logic [DATA_W-1:0] arr_data;
  logic              lru_we;
  logic              lru_val;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];

  // Lookup of the latched request; way 0 wins if both ways were ever to match
  always_comb begin
    hit0     = valid0[idx] && (tag0[idx] == tag);
    hit1     = valid1[idx] && (tag1[idx] == tag);
    hit      = hit0 || hit1;
    hit_way  = hit0 ? 1'b0 : 1'b1;
    hit_data = hit0 ? data0[idx] : data1[idx];
    if (!valid0[idx])      victim = 1'b0;
    else if (!valid1[idx]) victim = 1'b1;
    else                   victim = lru[idx];
  end

  // State register and request latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && P_strobe) begin
        addr_q  <= P_address;
        wdata_q <= P_wdata;
        rw_q    <= P_rw;
      end
      if (state == MEMRD && S_ready) rdata_q <= S_rdata;
    end
  end

  // Next-state logic and array update controls
  always_comb begin
    state_next  = state;
    arr_we      = 1'b0;
    arr_install = 1'b0;
    arr_way     = 1'b0;
    arr_data    = wdata_q;
    lru_we      = 1'b0;
    lru_val     = 1'b0;
    case (state)
      IDLE: if (P_strobe) state_next = COMPARE;
      COMPARE: begin
        if (rw_q) begin
          if (hit) begin
            lru_we     = 1'b1;
            lru_val    = ~hit_way;
            state_next = IDLE;
          end else begin
            state_next = MEMRD;
          end
        end else begin
          state_next = MEMWR;
          if (hit) begin
            arr_we  = 1'b1;
            arr_way = hit_way;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end else begin
`ifdef CACHE_WRITE_ALLOCATE_EN
            arr_we      = 1'b1;
            arr_install = 1'b1;
            arr_way     = victim;
            lru_we      = 1'b1;
            lru_val     = ~victim;
`endif
          end
        end
      end
      MEMRD: begin
        if (S_ready) begin
          arr_we      = 1'b1;
          arr_install = 1'b1;
          arr_way     = victim;
          arr_data    = S_rdata;
          lru_we      = 1'b1;
          lru_val     = ~victim;
          state_next  = RESP;
        end
      end
      MEMWR: if (S_ready) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Valid and LRU bits are cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      if (arr_we && arr_install) begin
        if (arr_way) valid1[idx] <= 1'b1;
        else         valid0[idx] <= 1'b1;
      end
      if (lru_we) lru[idx] <= lru_val;
    end
  end

  // Tag and data storage, not reset; writes only happen outside IDLE so reset blocks them
  always_ff @(posedge clk) begin
    if (arr_we) begin
      if (arr_way) begin
        data1[idx] <= arr_data;
        if (arr_install) tag1[idx] <= tag;
      end else begin
        data0[idx] <= arr_data;
        if (arr_install) tag0[idx] <= tag;
      end
    end
  end

  assign P_ready   = (state == RESP) || (state == COMPARE && rw_q && hit);
  assign P_rdata   = (state == COMPARE) ? hit_data : rdata_q;
  assign S_strobe  = (state == MEMRD) || (state == MEMWR);
  assign S_rw      = (state == MEMRD);
  assign S_address = addr_q;
  assign S_wdata   = wdata_q;

endmodule
